// File: rtl/l1_d_wb_pkg.sv
// Shared defaults and FSM state encoding for the L1 data-cache writeback buffer.
package l1_d_wb_pkg;

   localparam int unsigned ADDR_W_DEF = 26;   // {tag[19:0], index[5:0]}
   localparam int unsigned LINE_W_DEF = 512;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      FETCH = 2'd2,
      RESP  = 2'd3
   } wb_state_e;

endpackage

// File: rtl/l1_d_wb_fifo.sv
// Victim-line storage for the writeback buffer: circular FIFO with
// per-entry address compare and youngest-match data select.
module l1_d_wb_fifo
   import l1_d_wb_pkg::*;
#(
   parameter int unsigned DEPTH  = 2,
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned LINE_W = LINE_W_DEF
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic [ADDR_W-1:0]            push_addr,
   input  logic [LINE_W-1:0]            push_data,
   input  logic                         pop,
   input  logic [ADDR_W-1:0]            cmp_addr,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic [ADDR_W-1:0]            head_addr,
   output logic [LINE_W-1:0]            head_data,
   output logic [DEPTH-1:0]             match,
   output logic [LINE_W-1:0]            hit_data
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [LINE_W-1:0] data_q [DEPTH];
   logic [DEPTH-1:0]  valid_q;
   logic [PTR_W-1:0]  wr_ptr_q;
   logic [PTR_W-1:0]  rd_ptr_q;
   logic [CNT_W-1:0]  count_q;

   // Pointers, occupancy and valid bits; pointers wrap naturally (DEPTH is a power of 2)
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
            valid_q[wr_ptr_q] <= 1'b1;
         end
         if (pop) begin
            rd_ptr_q          <= rd_ptr_q + PTR_W'(1);
            valid_q[rd_ptr_q] <= 1'b0;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Line payload storage; contents are meaningful only where valid_q is set
   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[wr_ptr_q] <= push_addr;
         data_q[wr_ptr_q] <= push_data;
      end
   end

   // Address compare against every valid entry
   always_comb begin
      match = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         match[i] = valid_q[i] && (addr_q[i] == cmp_addr);
      end
   end

   // Walk oldest to youngest so the last (youngest) matching entry wins
   always_comb begin
      logic [PTR_W-1:0] idx;
      idx      = '0;
      hit_data = '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
         idx = rd_ptr_q + PTR_W'(k);
         if (match[idx]) begin
            hit_data = data_q[idx];
         end
      end
   end

   assign count     = count_q;
   assign head_addr = addr_q[rd_ptr_q];
   assign head_data = data_q[rd_ptr_q];

endmodule

// File: rtl/l1_d_wb_buffer.sv
// L1 data-cache writeback buffer: queues victim lines for L2 writeback and
// serves L1 refills, keeping refills coherent with lines still buffered.
// Optional feature macro WB_FORWARD_EN: a refill hitting a buffered (or
// same-cycle pushed) line is answered from the buffer without L2 access.
// When undefined, matching lines are drained to L2 before the refill fetch.
module l1_d_wb_buffer
   import l1_d_wb_pkg::*;
#(
   parameter int unsigned DEPTH  = 2,
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned LINE_W = LINE_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              write_L1_WB,
   input  logic [ADDR_W-1:0] wb_addr_L1_WB,
   input  logic [LINE_W-1:0] wb_data_L1_WB,
   output logic              wb_ready_WB_L1,
   input  logic              read_L1_WB,
   input  logic [ADDR_W-1:0] rd_addr_L1_WB,
   output logic              ready_WB_L1,
   output logic [LINE_W-1:0] read_data_WB_L1,
   output logic              write_WB_L2,
   output logic              read_WB_L2,
   output logic [ADDR_W-1:0] addr_WB_L2,
   output logic [LINE_W-1:0] wdata_WB_L2,
   input  logic              ready_L2_WB,
   input  logic [LINE_W-1:0] read_data_L2_WB
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   wb_state_e         state_q;
   wb_state_e         state_d;
   logic [ADDR_W-1:0] req_addr_q;
   logic [LINE_W-1:0] resp_data_q;
   logic [LINE_W-1:0] resp_data_d;
   logic              resp_load;

   logic              push;
   logic              pop;
   logic              push_hit;
   logic              any_match;
   logic [CNT_W-1:0]  count;
   logic [ADDR_W-1:0] head_addr;
   logic [LINE_W-1:0] head_data;
   logic [DEPTH-1:0]  fifo_match;
   logic [LINE_W-1:0] fifo_hit_data;
   logic [LINE_W-1:0] fwd_data;

   l1_d_wb_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .LINE_W (LINE_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_addr (wb_addr_L1_WB),
      .push_data (wb_data_L1_WB),
      .pop       (pop),
      .cmp_addr  (rd_addr_L1_WB),
      .count     (count),
      .head_addr (head_addr),
      .head_data (head_data),
      .match     (fifo_match),
      .hit_data  (fifo_hit_data)
   );

   assign wb_ready_WB_L1 = (count < CNT_W'(DEPTH));
   assign push           = write_L1_WB && wb_ready_WB_L1;
   assign pop            = (state_q == DRAIN) && ready_L2_WB;
   // A line pushed on the same edge is younger than anything already stored
   assign push_hit       = push && (wb_addr_L1_WB == rd_addr_L1_WB);
   assign any_match      = push_hit || (|fifo_match);
   assign fwd_data       = push_hit ? wb_data_L1_WB : fifo_hit_data;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Request address and refill data capture (qualified by state on the output side)
   always_ff @(posedge clk) begin
      if ((state_q == IDLE) && read_L1_WB) begin
         req_addr_q <= rd_addr_L1_WB;
      end
      if (resp_load) begin
         resp_data_q <= resp_data_d;
      end
   end

   // Next-state decode: refills beat drains in IDLE; L2 completions only count in DRAIN/FETCH
   always_comb begin
      state_d     = state_q;
      resp_load   = 1'b0;
      resp_data_d = (state_q == FETCH) ? read_data_L2_WB : fwd_data;
      case (state_q)
         IDLE: begin
            if (read_L1_WB) begin
               if (any_match) begin
`ifdef WB_FORWARD_EN
                  state_d   = RESP;
                  resp_load = 1'b1;
`else
                  state_d   = DRAIN;
`endif
               end else begin
                  state_d = FETCH;
               end
            end else if (count != '0) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (ready_L2_WB) begin
               state_d = IDLE;
            end
         end
         FETCH: begin
            if (ready_L2_WB) begin
               state_d   = RESP;
               resp_load = 1'b1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output decode from registered state and storage; everything idles at zero
   assign ready_WB_L1     = (state_q == RESP);
   assign read_data_WB_L1 = (state_q == RESP) ? resp_data_q : '0;
   assign write_WB_L2     = (state_q == DRAIN);
   assign read_WB_L2      = (state_q == FETCH);
   assign addr_WB_L2      = (state_q == DRAIN) ? head_addr :
                            (state_q == FETCH) ? req_addr_q : '0;
   assign wdata_WB_L2     = (state_q == DRAIN) ? head_data : '0;

endmodule
